// File: rtl/operate_sequencer_pkg.sv
// Shared types, widths and IR bit positions for the PDP-8 operate-instruction sequencer.
// The optional RTR/RTL double rotate is enabled by defining DOUBLE_ROTATE_EN.
package pdp8_micro_pkg;

  localparam int unsigned WORD_W    = 12;
  localparam int unsigned LINK_AC_W = WORD_W + 1;
  localparam int unsigned IR_W      = 9;

  // Local stand-in for the memory_utils word type
  typedef logic [WORD_W-1:0] word;

  typedef enum logic [3:0] {
    IDLE, EV1, EV2, EV3, EV4, EV5, G2SKP, G2CLR, G2OSR, DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    ROT_NONE, ROT_RIGHT, ROT_LEFT, ROT_BSW
  } rot_op_t;

  localparam int unsigned IR_GRP = 8;
  localparam int unsigned G3_SEL = 0;

  localparam int unsigned G1_CLA = 7;
  localparam int unsigned G1_CLL = 6;
  localparam int unsigned G1_CMA = 5;
  localparam int unsigned G1_CML = 4;
  localparam int unsigned G1_RAR = 3;
  localparam int unsigned G1_RAL = 2;
  localparam int unsigned G1_BSW = 1;
  localparam int unsigned G1_IAC = 0;

  localparam int unsigned G2_CLA = 7;
  localparam int unsigned G2_SMA = 6;
  localparam int unsigned G2_SZA = 5;
  localparam int unsigned G2_SNL = 4;
  localparam int unsigned G2_AND = 3;
  localparam int unsigned G2_OSR = 2;
  localparam int unsigned G2_HLT = 1;

  // AND-group skip is the complement of the OR-group sense; all-zero AND is SKP
  function automatic logic g2_skip(input logic [IR_W-2:0] ir, input word ac, input logic l);
    logic sense;
    sense = (ir[G2_SMA] & ac[WORD_W-1]) | (ir[G2_SZA] & (ac == '0)) | (ir[G2_SNL] & l);
    return ir[G2_AND] ? ~sense : sense;
  endfunction

endpackage

// File: rtl/operate_sequencer_if.sv
// Start/done handshake and AC/L data bus between the instruction FSM and the operate sequencer.
interface operate_sequencer_if;
  import pdp8_micro_pkg::*;

  logic                start;
  logic [IR_W-1:0]     i_reg;
  word                 ac_in;
  logic                l_in;
  word                 sr;
  logic                ready;
  logic                done;
  word                 ac_out;
  logic                l_out;
  logic                skip;
  logic                halt;
  logic                unsup;

  modport master (
    output start, i_reg, ac_in, l_in, sr,
    input  ready, done, ac_out, l_out, skip, halt, unsup
  );

  modport slave (
    input  start, i_reg, ac_in, l_in, sr,
    output ready, done, ac_out, l_out, skip, halt, unsup
  );
endinterface

// File: rtl/operate_sequencer_rotator.sv
// Combinational rotate right/left and byte swap of the 13-bit {L,AC} pair.
module link_ac_rotator
  import pdp8_micro_pkg::*;
(
  input  logic [LINK_AC_W-1:0] la_i,
  input  rot_op_t              op_i,
  output logic [LINK_AC_W-1:0] la_o
);

  // Byte swap exchanges the AC halves and leaves the link in place
  always_comb begin
    la_o = la_i;
    case (op_i)
      ROT_RIGHT: la_o = {la_i[0], la_i[LINK_AC_W-1:1]};
      ROT_LEFT:  la_o = {la_i[LINK_AC_W-2:0], la_i[LINK_AC_W-1]};
      ROT_BSW:   la_o = {la_i[LINK_AC_W-1], la_i[5:0], la_i[WORD_W-1:6]};
      default:   la_o = la_i;
    endcase
  end

endmodule

// File: rtl/operate_sequencer.sv
// PDP-8 operate-instruction sequencer: Group 1/2 micro-ops on AC/L, one event per cycle.
// Define DOUBLE_ROTATE_EN to execute RTR/RTL as two rotates (extra EV5 cycle).
module operate_sequencer
  import pdp8_micro_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  operate_sequencer_if.slave bus
);

  seq_state_t            state_q;
  logic [IR_W-2:0]       ir_q;
  word                   ac_q;
  word                   sr_q;
  logic                  l_q;
  word                   ac_out_q;
  logic                  l_out_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  skip_q;
  logic                  halt_q;
  logic                  unsup_q;

  rot_op_t               rot_op;
  logic [LINK_AC_W-1:0]  rot_res;
  logic                  double_rot;
  word                   osr_ac;

  // RAR and RAL together cancel; BSW only acts alone or as the RTR/RTL modifier
  always_comb begin
    rot_op = ROT_NONE;
    if (ir_q[G1_RAR] && !ir_q[G1_RAL]) begin
      rot_op = ROT_RIGHT;
    end else if (ir_q[G1_RAL] && !ir_q[G1_RAR]) begin
      rot_op = ROT_LEFT;
    end else if (ir_q[G1_BSW] && !ir_q[G1_RAR] && !ir_q[G1_RAL]) begin
      rot_op = ROT_BSW;
    end
  end

`ifdef DOUBLE_ROTATE_EN
  assign double_rot = ir_q[G1_BSW] & (ir_q[G1_RAR] ^ ir_q[G1_RAL]);
`else
  assign double_rot = 1'b0;
`endif

  assign osr_ac = ac_q | (ir_q[G2_OSR] ? sr_q : WORD_W'(0));

  link_ac_rotator u_rot (
    .la_i ({l_q, ac_q}),
    .op_i (rot_op),
    .la_o (rot_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      ac_q     <= '0;
      sr_q     <= '0;
      l_q      <= 1'b0;
      ac_out_q <= '0;
      l_out_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      skip_q   <= 1'b0;
      halt_q   <= 1'b0;
      unsup_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ir_q    <= bus.i_reg[IR_W-2:0];
            ac_q    <= bus.ac_in;
            l_q     <= bus.l_in;
            sr_q    <= bus.sr;
            ready_q <= 1'b0;
            skip_q  <= 1'b0;
            halt_q  <= 1'b0;
            unsup_q <= 1'b0;
            if (!bus.i_reg[IR_GRP]) begin
              state_q <= EV1;
            end else if (bus.i_reg[G3_SEL]) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              unsup_q  <= 1'b1;
              ac_out_q <= bus.ac_in;
              l_out_q  <= bus.l_in;
            end else begin
              state_q <= G2SKP;
            end
          end
        end
        EV1: begin
          if (ir_q[G1_CLA]) ac_q <= '0;
          if (ir_q[G1_CLL]) l_q  <= 1'b0;
          state_q <= EV2;
        end
        EV2: begin
          if (ir_q[G1_CMA]) ac_q <= ~ac_q;
          if (ir_q[G1_CML]) l_q  <= ~l_q;
          state_q <= EV3;
        end
        EV3: begin
          if (ir_q[G1_IAC]) {l_q, ac_q} <= {l_q, ac_q} + LINK_AC_W'(1);
          state_q <= EV4;
        end
        EV4: begin
          {l_q, ac_q} <= rot_res;
          if (double_rot) begin
            state_q <= EV5;
          end else begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            ac_out_q <= rot_res[WORD_W-1:0];
            l_out_q  <= rot_res[WORD_W];
          end
        end
        EV5: begin
          {l_q, ac_q} <= rot_res;
          state_q  <= DONE;
          done_q   <= 1'b1;
          ac_out_q <= rot_res[WORD_W-1:0];
          l_out_q  <= rot_res[WORD_W];
        end
        G2SKP: begin
          skip_q  <= g2_skip(ir_q, ac_q, l_q);
          state_q <= G2CLR;
        end
        G2CLR: begin
          if (ir_q[G2_CLA]) ac_q <= '0;
          state_q <= G2OSR;
        end
        G2OSR: begin
          ac_q     <= osr_ac;
          halt_q   <= ir_q[G2_HLT];
          state_q  <= DONE;
          done_q   <= 1'b1;
          ac_out_q <= osr_ac;
          l_out_q  <= l_q;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.ac_out = ac_out_q;
  assign bus.l_out  = l_out_q;
  assign bus.skip   = skip_q;
  assign bus.halt   = halt_q;
  assign bus.unsup  = unsup_q;

endmodule

// File: tb/tb_operate_sequencer.sv
// Scoreboard bench for operate_sequencer: driver queues expected results, negedge monitor checks on done.
// Expectations for RTR follow DOUBLE_ROTATE_EN when the bench is built with it.
module tb_operate_sequencer;
  import pdp8_micro_pkg::*;

  typedef struct {
    word  ac;
    logic l;
    logic skip;
    logic halt;
    logic unsup;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  operate_sequencer_if bus ();

  operate_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0o, expected %0o (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done) begin
      check("done_one_cycle", 32'(prev_done), 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending result (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("ac_out", 32'(bus.ac_out), 32'(e.ac));
        check("l_out",  32'(bus.l_out),  32'(e.l));
        check("skip",   32'(bus.skip),   32'(e.skip));
        check("halt",   32'(bus.halt),   32'(e.halt));
        check("unsup",  32'(bus.unsup),  32'(e.unsup));
        if (e.lat > 0) check("latency", 32'(cyc - acc_cyc), 32'(e.lat));
      end
    end
    prev_done = bus.done;
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
  endtask

  task automatic run(input logic [8:0] ir, input word ac, input logic l, input word sr,
                     input word e_ac, input logic e_l, input logic e_skip, input logic e_halt,
                     input logic e_unsup, input int lat, input int noise);
    exp_t e;
    int   t;
    wait_ready();
    bus.i_reg = ir;
    bus.ac_in = ac;
    bus.l_in  = l;
    bus.sr    = sr;
    bus.start = 1'b1;
    e.ac = e_ac; e.l = e_l; e.skip = e_skip; e.halt = e_halt; e.unsup = e_unsup; e.lat = lat;
    exp_q.push_back(e);
    acc_cyc = cyc;
    @(negedge clk);
    if (noise > 0) begin
      bus.i_reg = 9'o001;
      bus.ac_in = '1;
      repeat (noise) @(negedge clk);
    end
    bus.start = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done for ir=%0o, expected done within 20 cycles", ir);
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.i_reg = '0;
    bus.ac_in = '0;
    bus.l_in  = 1'b0;
    bus.sr    = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready",  32'(bus.ready),  32'd1);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_ac_out", 32'(bus.ac_out), 32'd0);
    check("rst_l_out",  32'(bus.l_out),  32'd0);
    check("rst_skip",   32'(bus.skip),   32'd0);
    check("rst_halt",   32'(bus.halt),   32'd0);
    check("rst_unsup",  32'(bus.unsup),  32'd0);

    // Group 1: ir, ac, l, sr -> ac, l, skip, halt, unsup, latency, start noise
    run(9'o341, 12'o1234, 1'b0, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    run(9'o361, 12'o7777, 1'b0, 12'o0, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);
    run(9'o004, 12'o4000, 1'b0, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
`ifdef DOUBLE_ROTATE_EN
    run(9'o012, 12'o0003, 1'b0, 12'o0, 12'o4000, 1'b1, 1'b0, 1'b0, 1'b0, 6, 0);
`else
    run(9'o012, 12'o0003, 1'b0, 12'o0, 12'o0001, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
`endif
    run(9'o002, 12'o1234, 1'b1, 12'o0, 12'o3412, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    run(9'o014, 12'o1234, 1'b1, 12'o0, 12'o1234, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    run(9'o010, 12'o0001, 1'b0, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);

    // Group 2
    run(9'o460, 12'o0000, 1'b0, 12'o0, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0);
    run(9'o570, 12'o4000, 1'b0, 12'o0, 12'o4000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
    run(9'o770, 12'o4000, 1'b0, 12'o0, 12'o0000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 0);
    run(9'o770, 12'o0001, 1'b0, 12'o0, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0);
    run(9'o410, 12'o5555, 1'b1, 12'o0, 12'o5555, 1'b1, 1'b1, 1'b0, 1'b0, 4, 0);
    run(9'o606, 12'o5555, 1'b1, 12'o1234, 12'o1234, 1'b1, 1'b0, 1'b1, 1'b0, 4, 2);
    repeat (4) @(negedge clk);

    // halt from the previous run clears on the next accepted start
    run(9'o001, 12'o0005, 1'b0, 12'o0, 12'o0006, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0);

    // Reset in EV3 aborts the sequence; no done may follow
    wait_ready();
    bus.i_reg = 9'o361;
    bus.ac_in = 12'o7777;
    bus.l_in  = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready",  32'(bus.ready),  32'd1);
    check("abort_ac_out", 32'(bus.ac_out), 32'd0);
    check("abort_l_out",  32'(bus.l_out),  32'd0);
    check("abort_done",   32'(bus.done),   32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Group 3 passes AC/L through; unsup then clears on the next start
    run(9'o401, 12'o2525, 1'b1, 12'o0, 12'o2525, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
    run(9'o001, 12'o7777, 1'b0, 12'o0, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected completion before 200000 time units");
    $fatal(1);
  end

endmodule
